// File: rtl/core_wb_pkg.sv
// Shared types and constants for the Selen writeback stage.
package core_wb_pkg;

  localparam int LQ_DEPTH_DEF = 2;

  localparam logic [1:0] WB_SZ_B = 2'd0;
  localparam logic [1:0] WB_SZ_H = 2'd1;
  localparam logic [1:0] WB_SZ_W = 2'd2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_lq_entry_t;

endpackage

// File: rtl/core_wb_lq.sv
// In-order load queue; pointers carry an extra wrap bit to tell full from empty.
module core_wb_lq
  import core_wb_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  wb_lq_entry_t push_data,
  input  logic         pop,
  output wb_lq_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_lq_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage holds data only; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/core_wb_unit.sv
// Writeback stage: arbitrates ALU results and LSU loads onto the single
// register-file write port and tracks registers with loads in flight.
module core_wb_unit
  import core_wb_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_vld,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue_vld,
  input  logic [4:0]  ld_issue_rd,
  input  logic        lsu_vld,
  output logic        lsu_rdy,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic [1:0]  lsu_addr_lo,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_sign,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic [31:0] ld_busy
);

  function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                           input logic [1:0]  lo,
                                           input logic [1:0]  sz,
                                           input logic        sgn);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = d >> {lo, 3'b000};
    b  = sh[7:0];
    h  = lo[1] ? d[31:16] : d[15:0];
    case (sz)
      WB_SZ_B: fmt_load = {{24{sgn & b[7]}}, b};
      WB_SZ_H: fmt_load = {{16{sgn & h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  wb_lq_entry_t lq_head;
  wb_lq_entry_t lq_in;
  logic         lq_full;
  logic         lq_empty;
  logic         lq_push;
  logic         lq_pop;

  logic         lsu_acc;
  logic         alu_win;
  logic         head_win;
  logic         byp_win;
  logic         wr_vld;
  logic [4:0]   wr_rd;
  logic [31:0]  wr_data;
  logic         ld_wr;
  logic [31:0]  busy_set;
  logic [31:0]  busy_clr;
  logic [31:0]  busy_nxt;

  logic         vld_p1;
  logic [4:0]   rd_p1;
  logic [31:0]  data_p1;
  logic [31:0]  busy_p1;

  assign lsu_rdy  = !lq_full;
  assign lsu_acc  = lsu_vld && lsu_rdy;
  assign lq_in.rd   = lsu_rd;
  assign lq_in.data = fmt_load(lsu_data, lsu_addr_lo, lsu_size, lsu_sign);

  // x0 writes never take a slot; rd=0 loads are accepted and discarded.
  assign alu_win  = alu_vld && (alu_rd != 5'd0);
  assign head_win = !alu_win && !lq_empty;
  assign byp_win  = !alu_win && lq_empty && lsu_acc && (lsu_rd != 5'd0);
  assign lq_push  = lsu_acc && (lsu_rd != 5'd0) && !byp_win;
  assign lq_pop   = head_win;
  assign ld_wr    = head_win || byp_win;

  always_comb begin
    wr_vld  = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    if (alu_win) begin
      wr_vld  = 1'b1;
      wr_rd   = alu_rd;
      wr_data = alu_data;
    end else if (head_win) begin
      wr_vld  = 1'b1;
      wr_rd   = lq_head.rd;
      wr_data = lq_head.data;
    end else if (byp_win) begin
      wr_vld  = 1'b1;
      wr_rd   = lq_in.rd;
      wr_data = lq_in.data;
    end
  end

  // A new issue to the same register outranks the completing load.
  always_comb begin
    busy_set = 32'd0;
    busy_clr = 32'd0;
    if (ld_issue_vld) busy_set[ld_issue_rd] = 1'b1;
    if (ld_wr)        busy_clr[wr_rd]       = 1'b1;
    busy_nxt = ((busy_p1 & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
  end

  core_wb_lq #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push),
    .push_data (lq_in),
    .pop       (lq_pop),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // ---- stage p1: registered write port and scoreboard ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= 5'd0;
      data_p1 <= 32'd0;
      busy_p1 <= 32'd0;
    end else begin
      vld_p1  <= wr_vld;
      busy_p1 <= busy_nxt;
      if (wr_vld) begin
        rd_p1   <= wr_rd;
        data_p1 <= wr_data;
      end
    end
  end

  assign rf_we   = vld_p1;
  assign rf_rd   = rd_p1;
  assign rf_data = data_p1;
  assign ld_busy = busy_p1;

endmodule

// File: tb/tb_core_wb_unit.sv
// Directed bench for core_wb_unit: vector table plus multi-cycle sequences.
module tb_core_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_vld;
  logic [4:0]  ld_issue_rd;
  logic        lsu_vld;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [1:0]  lsu_addr_lo;
  logic [1:0]  lsu_size;
  logic        lsu_sign;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] ld_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_wb_unit #(.LQ_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_vld      (alu_vld),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_issue_vld (ld_issue_vld),
    .ld_issue_rd  (ld_issue_rd),
    .lsu_vld      (lsu_vld),
    .lsu_rdy      (lsu_rdy),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_addr_lo  (lsu_addr_lo),
    .lsu_size     (lsu_size),
    .lsu_sign     (lsu_sign),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .ld_busy      (ld_busy)
  );

  typedef struct {
    string       name;
    logic        alu_vld;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_vld;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [1:0]  lo;
    logic [1:0]  sz;
    logic        sgn;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string nm, logic av, logic [4:0] ar, logic [31:0] ad,
                              logic lv, logic [4:0] lr, logic [31:0] ld,
                              logic [1:0] lo, logic [1:0] sz, logic sg,
                              logic ew, logic [4:0] er, logic [31:0] ed);
    vec_t v;
    v.name = nm; v.alu_vld = av; v.alu_rd = ar; v.alu_data = ad;
    v.lsu_vld = lv; v.lsu_rd = lr; v.lsu_data = ld; v.lo = lo; v.sz = sz; v.sgn = sg;
    v.exp_we = ew; v.exp_rd = er; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_vld = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue_vld = 1'b0; ld_issue_rd = 5'd0;
    lsu_vld = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    lsu_addr_lo = 2'd0; lsu_size = 2'd2; lsu_sign = 1'b0;
  endtask

  localparam logic [31:0] LD_W = 32'h80F1_7F82;

  initial begin
    vecs[0]  = mk("alu_rd5",      1, 5, 32'hDEAD_BEEF, 0, 0, 0,    0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    vecs[1]  = mk("alu_rd0",      1, 0, 32'h1234_5678, 0, 0, 0,    0, 0, 0, 0, 0, 0);
    vecs[2]  = mk("ld_b0_s",      0, 0, 0,             1, 6, LD_W, 0, 0, 1, 1, 6, 32'hFFFF_FF82);
    vecs[3]  = mk("ld_b1_u",      0, 0, 0,             1, 6, LD_W, 1, 0, 0, 1, 6, 32'h0000_007F);
    vecs[4]  = mk("ld_h2_s",      0, 0, 0,             1, 6, LD_W, 2, 1, 1, 1, 6, 32'hFFFF_80F1);
    vecs[5]  = mk("ld_w",         0, 0, 0,             1, 6, LD_W, 0, 2, 1, 1, 6, 32'h80F1_7F82);
    vecs[6]  = mk("ld_b3_s",      0, 0, 0,             1, 10, LD_W, 3, 0, 1, 1, 10, 32'hFFFF_FF80);
    vecs[7]  = mk("ld_h3_u",      0, 0, 0,             1, 11, LD_W, 3, 1, 0, 1, 11, 32'h0000_80F1);
    vecs[8]  = mk("ld_sz3_off1",  0, 0, 0,             1, 12, LD_W, 1, 3, 1, 1, 12, 32'h80F1_7F82);
    vecs[9]  = mk("ld_rd0_drop",  0, 0, 0,             1, 0, LD_W, 0, 2, 0, 0, 0, 0);
    vecs[10] = mk("alu0_ld_byp",  1, 0, 32'hFFFF_FFFF, 1, 4, LD_W, 0, 1, 0, 1, 4, 32'h0000_7F82);

    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_rf_we",   {31'd0, rf_we},   32'd0);
    chk("rst_rf_rd",   {27'd0, rf_rd},   32'd0);
    chk("rst_rf_data", rf_data,          32'd0);
    chk("rst_ld_busy", ld_busy,          32'd0);
    chk("rst_lsu_rdy", {31'd0, lsu_rdy}, 32'd1);

    // Table: one transaction, result checked the following cycle, then one idle cycle.
    for (int i = 0; i < 11; i++) begin
      alu_vld = vecs[i].alu_vld; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_data;
      lsu_vld = vecs[i].lsu_vld; lsu_rd = vecs[i].lsu_rd; lsu_data = vecs[i].lsu_data;
      lsu_addr_lo = vecs[i].lo; lsu_size = vecs[i].sz; lsu_sign = vecs[i].sgn;
      tick();
      idle();
      chk({vecs[i].name, "_we"}, {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        chk({vecs[i].name, "_rd"},   {27'd0, rf_rd}, {27'd0, vecs[i].exp_rd});
        chk({vecs[i].name, "_data"}, rf_data,        vecs[i].exp_data);
      end
      tick();
      chk({vecs[i].name, "_one_cycle"}, {31'd0, rf_we}, 32'd0);
    end

    // Conflict: ALU rd3 cycles 1-4, loads rd7/rd8 cycles 1-2.
    for (int c = 1; c <= 8; c++) begin
      idle();
      if (c <= 4) begin alu_vld = 1'b1; alu_rd = 5'd3; alu_data = 32'h300 + c; end
      if (c == 1) begin lsu_vld = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1111_0007; end
      if (c == 2) begin lsu_vld = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h2222_0008; end
      if (c == 1) chk("cf_rdy_c1", {31'd0, lsu_rdy}, 32'd1);
      if (c == 3) chk("cf_rdy_c3", {31'd0, lsu_rdy}, 32'd0);
      if (c == 6) chk("cf_rdy_c6", {31'd0, lsu_rdy}, 32'd1);
      tick();
      if (c + 1 <= 5) begin
        chk("cf_alu_we", {31'd0, rf_we}, 32'd1);
        chk("cf_alu_rd", {27'd0, rf_rd}, 32'd3);
        chk("cf_alu_data", rf_data, 32'h300 + c);
      end else if (c + 1 == 6) begin
        chk("cf_ld7_we", {31'd0, rf_we}, 32'd1);
        chk("cf_ld7_rd", {27'd0, rf_rd}, 32'd7);
        chk("cf_ld7_data", rf_data, 32'h1111_0007);
      end else if (c + 1 == 7) begin
        chk("cf_ld8_we", {31'd0, rf_we}, 32'd1);
        chk("cf_ld8_rd", {27'd0, rf_rd}, 32'd8);
        chk("cf_ld8_data", rf_data, 32'h2222_0008);
      end else begin
        chk("cf_drain_we", {31'd0, rf_we}, 32'd0);
      end
    end
    idle();

    // Scoreboard.
    ld_issue_vld = 1'b1; ld_issue_rd = 5'd9;
    tick(); idle();
    chk("sb_set9", ld_busy, 32'h0000_0200);
    ld_issue_vld = 1'b1; ld_issue_rd = 5'd0;
    tick(); idle();
    chk("sb_x0_never", ld_busy, 32'h0000_0200);
    alu_vld = 1'b1; alu_rd = 5'd9; alu_data = 32'h5;
    tick(); idle();
    chk("sb_alu_keeps", ld_busy, 32'h0000_0200);
    lsu_vld = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick(); idle();
    chk("sb_clr_we", {31'd0, rf_we}, 32'd1);
    chk("sb_clr_rd", {27'd0, rf_rd}, 32'd9);
    chk("sb_clr9", ld_busy, 32'd0);
    ld_issue_vld = 1'b1; ld_issue_rd = 5'd9;
    tick(); idle();
    lsu_vld = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9A;
    ld_issue_vld = 1'b1; ld_issue_rd = 5'd9;
    tick(); idle();
    chk("sb_reissue_we", {31'd0, rf_we}, 32'd1);
    chk("sb_set_wins", ld_busy, 32'h0000_0200);
    lsu_vld = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9B;
    tick(); idle();
    chk("sb_clr9_again", ld_busy, 32'd0);

    // Reset mid-operation with two queued loads.
    ld_issue_vld = 1'b1; ld_issue_rd = 5'd8;
    tick(); idle();
    ld_issue_vld = 1'b1; ld_issue_rd = 5'd9;
    tick(); idle();
    alu_vld = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    lsu_vld = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
    tick(); idle();
    alu_vld = 1'b1; alu_rd = 5'd1; alu_data = 32'hB;
    lsu_vld = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick(); idle();
    chk("mr_busy_pre", ld_busy, 32'h0000_0300);
    chk("mr_full", {31'd0, lsu_rdy}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_rf_we",   {31'd0, rf_we},   32'd0);
    chk("mr_rf_rd",   {27'd0, rf_rd},   32'd0);
    chk("mr_rf_data", rf_data,          32'd0);
    chk("mr_ld_busy", ld_busy,          32'd0);
    chk("mr_lsu_rdy", {31'd0, lsu_rdy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_no_stale_write", {31'd0, rf_we}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
